// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU that feeds the accumulator.
package alu_pkg;

    localparam int WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_MUL  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier datapath: one partial product per step, WIDTH steps.
module shift_add_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   mcand_in,
    input  logic [WIDTH-1:0]   mplier_in,
    output logic               last,
    output logic [2*WIDTH-1:0] prod_next
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      cnt;

    // Exposed so the final step's sum can be registered as the result on the same edge.
    assign prod_next = mplier[0] ? (prod + mcand) : prod;
    assign last      = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= {{WIDTH{1'b0}}, mcand_in};
            mplier <= mplier_in;
            prod   <= '0;
            cnt    <= '0;
        end else if (step) begin
            prod   <= prod_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU driving the accumulator's alu_in with a one-cycle alu_load strobe.
//   state  | meaning
//   S_IDLE | waiting for start; PASS/ADD/SUB complete on the accepting edge
//   S_MUL  | one shift-add iteration per cycle, WIDTH iterations
//   S_DONE | result valid, alu_load high for this single cycle
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             alu_load,
    output logic             busy,
    output logic             ovf
);

    state_e             state, state_d;
    logic [WIDTH-1:0]   result_d;
    logic               ovf_d;
    logic               mul_load, mul_step, mul_last;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH:0]     sum_ext, diff_ext;

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

    shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (mul_load),
        .step      (mul_step),
        .mcand_in  (a),
        .mplier_in (b),
        .last      (mul_last),
        .prod_next (prod_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            result <= '0;
            ovf    <= 1'b0;
        end else begin
            state  <= state_d;
            result <= result_d;
            ovf    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state;
        result_d = result;
        ovf_d    = ovf;
        mul_load = 1'b0;
        mul_step = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DONE;
                    case (op_e'(op))
                        OP_PASS: begin
                            result_d = b;
                            ovf_d    = 1'b0;
                        end
                        OP_ADD: begin
                            result_d = sum_ext[WIDTH-1:0];
                            ovf_d    = sum_ext[WIDTH];
                        end
                        OP_SUB: begin
                            // Borrow out of the extended subtraction is exactly a < b.
                            result_d = diff_ext[WIDTH-1:0];
                            ovf_d    = diff_ext[WIDTH];
                        end
                        OP_MUL: begin
                            mul_load = 1'b1;
                            state_d  = S_MUL;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_MUL: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    result_d = prod_next[WIDTH-1:0];
                    ovf_d    = |prod_next[2*WIDTH-1:WIDTH];
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign alu_load = (state == S_DONE);
    assign busy     = (state != S_IDLE);

endmodule
